// File: rtl/dbg_disp_sched_if.sv
// ---------------------------------------------------------------------------
// dbg_disp_sched_if
//
// Purpose:
//   Bundles the debug-source taps, the user controls and the display-side
//   outputs of the debug display scheduler into one interface.
//
// Signals:
//   src_data   NSRC*16  source values, source i at [16i+15:16i]
//   src_dots   NSRC*4   source dot patterns, source i at [4i+3:4i]
//   src_valid  NSRC     source present flags
//   btn_next   1        single-cycle pulse: advance page
//   btn_mode   1        single-cycle pulse: toggle AUTO/MANUAL
//   freeze     1        level: hold display and page
//   scan_ce    1        one-cycle scan tick to the digit multiplexer
//   out_data   16       display value (decoder data0)
//   out_dots   4        dot pattern (decoder data1)
//   page       SEL_W    currently selected source
//   manual     1        1 = MANUAL mode
//
// Modports:
//   master  the scheduler itself (consumes sources/controls, drives display)
//   slave   the surrounding environment (drives sources/controls)
// ---------------------------------------------------------------------------
interface dbg_disp_sched_if #(
    parameter int NSRC  = 4,
    parameter int SEL_W = 2
);
    logic [NSRC*16-1:0] src_data;
    logic [NSRC*4-1:0]  src_dots;
    logic [NSRC-1:0]    src_valid;
    logic               btn_next;
    logic               btn_mode;
    logic               freeze;
    logic               scan_ce;
    logic [15:0]        out_data;
    logic [3:0]         out_dots;
    logic [SEL_W-1:0]   page;
    logic               manual;

    modport master (
        input  src_data, src_dots, src_valid, btn_next, btn_mode, freeze,
        output scan_ce, out_data, out_dots, page, manual
    );

    modport slave (
        output src_data, src_dots, src_valid, btn_next, btn_mode, freeze,
        input  scan_ce, out_data, out_dots, page, manual
    );
endinterface

// File: rtl/dbg_disp_sched.sv
// ---------------------------------------------------------------------------
// dbg_disp_sched
//
// Purpose:
//   Shares the 4-digit 7-segment debug display between NSRC debug sources.
//   Generates the scan clock-enable for the digit multiplexer, rotates the
//   selected page automatically (AUTO) or on button presses (MANUAL), and
//   registers a tear-free snapshot of the selected source for the decoder.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   dbg_disp_sched_if.master (sources, controls, display outputs)
//
// Optional feature:
//   DBG_PAGE_BANNER_EN - when defined, every page change shows a banner
//   word {E,0,0,page} with dots 4'b1000 for BANNER_TICKS scan ticks before
//   normal source data is shown again.
// ---------------------------------------------------------------------------
module dbg_disp_sched #(
    parameter int NSRC         = 4,
    parameter int SEL_W        = 2,
    parameter int SCAN_DIV     = 50000,
    parameter int PAGE_DIV     = 2000
`ifdef DBG_PAGE_BANNER_EN
    ,
    parameter int BANNER_TICKS = 500
`endif
) (
    input logic               clk,
    input logic               rst,
    dbg_disp_sched_if.master  bus
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int PAGE_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;

    typedef enum logic {
        AUTO   = 1'b0,
        MANUAL = 1'b1
    } mode_t;

    mode_t              mode_q;
    mode_t              mode_d;
    logic [SCAN_W-1:0]  scan_cnt;
    logic               scan_ce;
    logic [PAGE_W-1:0]  page_cnt;
    logic [PAGE_W-1:0]  page_cnt_d;
    logic [SEL_W-1:0]   page_q;
    logic [SEL_W-1:0]   page_d;
    logic [SEL_W-1:0]   next_idx;
    logic [SEL_W:0]     cand;
    logic               found;
    logic               page_chg_q;
    logic               auto_adv;
    logic               next_ok;
    logic [15:0]        data_q;
    logic [3:0]         dots_q;
    logic [15:0]        load_data;
    logic [3:0]         load_dots;

    // Free-running scan prescaler; keeps running while frozen so the digit
    // multiplexer never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_ce) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign scan_ce = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Search for the first valid source after the current page, wrapping
    // modulo NSRC. The current page itself is never a candidate, so with no
    // other valid source the page simply holds.
    always_comb begin
        next_idx = page_q;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k < NSRC; k++) begin
            cand = {1'b0, page_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NSRC)) begin
                cand = cand - (SEL_W+1)'(NSRC);
            end
            if (!found && bus.src_valid[cand[SEL_W-1:0]]) begin
                next_idx = cand[SEL_W-1:0];
                found    = 1'b1;
            end
        end
    end

    // Mode FSM next state plus page stepping. An auto-advance and btn_next in
    // the same cycle collapse into a single step; a mode toggle and a step in
    // the same cycle both take effect.
    always_comb begin
        mode_d     = mode_q;
        page_d     = page_q;
        page_cnt_d = page_cnt;
        auto_adv   = 1'b0;
        next_ok    = bus.btn_next && !bus.freeze;

        if (mode_q == AUTO && !bus.freeze && scan_ce &&
            page_cnt == PAGE_W'(PAGE_DIV - 1)) begin
            auto_adv = 1'b1;
        end

        if (auto_adv || next_ok) begin
            page_d = next_idx;
        end

        if (bus.btn_mode) begin
            mode_d     = (mode_q == AUTO) ? MANUAL : AUTO;
            page_cnt_d = '0;
        end else if (mode_q == AUTO) begin
            if (next_ok || auto_adv) begin
                page_cnt_d = '0;
            end else if (!bus.freeze && scan_ce) begin
                page_cnt_d = page_cnt + PAGE_W'(1);
            end
        end
    end

    // State register for mode, page and page counter. page_chg_q remembers a
    // page change so the display reloads one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= AUTO;
            page_q     <= '0;
            page_cnt   <= '0;
            page_chg_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            page_q     <= page_d;
            page_cnt   <= page_cnt_d;
            page_chg_q <= (page_d != page_q);
        end
    end

    // Selected source word; an absent source displays as all zeros.
    always_comb begin
        load_data = 16'h0000;
        load_dots = 4'h0;
        if (bus.src_valid[page_q]) begin
            load_data = bus.src_data[{page_q, 4'b0000} +: 16];
            load_dots = bus.src_dots[{page_q, 2'b00} +: 4];
        end
    end

`ifdef DBG_PAGE_BANNER_EN
    localparam int BAN_W = $clog2(BANNER_TICKS + 1);

    logic [BAN_W-1:0] banner_cnt;

    // Snapshot register with page banner. banner_cnt holds the scan ticks the
    // banner still has to stay up; the tick that brings it to the end is the
    // one that reloads source data. A new page change restarts the banner,
    // and freeze holds everything including the banner countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= 16'h0000;
            dots_q     <= 4'h0;
            banner_cnt <= '0;
        end else if (!bus.freeze) begin
            if (page_chg_q) begin
                data_q     <= {4'hE, 8'h00, 4'(page_q)};
                dots_q     <= 4'b1000;
                banner_cnt <= BAN_W'(BANNER_TICKS);
            end else if (scan_ce) begin
                if (banner_cnt > BAN_W'(1)) begin
                    banner_cnt <= banner_cnt - BAN_W'(1);
                end else begin
                    banner_cnt <= '0;
                    data_q     <= load_data;
                    dots_q     <= load_dots;
                end
            end
        end
    end
`else
    // Snapshot register: refresh on every scan tick and force a reload the
    // cycle after a page change so the new page shows with 1-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 16'h0000;
            dots_q <= 4'h0;
        end else if (!bus.freeze && (scan_ce || page_chg_q)) begin
            data_q <= load_data;
            dots_q <= load_dots;
        end
    end
`endif

    assign bus.scan_ce  = scan_ce;
    assign bus.out_data = data_q;
    assign bus.out_dots = dots_q;
    assign bus.page     = page_q;
    assign bus.manual   = (mode_q == MANUAL);

endmodule

// File: tb/tb_dbg_disp_sched.sv
// ---------------------------------------------------------------------------
// tb_dbg_disp_sched
//
// Purpose:
//   Self-checking bench for dbg_disp_sched. Directed scenarios followed by a
//   randomized run, all compared against a behavioural reference model.
//   Honours DBG_PAGE_BANNER_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dbg_disp_sched;

    localparam int NSRC     = 4;
    localparam int SEL_W    = 2;
    localparam int SCAN_DIV = 4;
    localparam int PAGE_DIV = 3;
`ifdef DBG_PAGE_BANNER_EN
    localparam int BANNER_TICKS = 2;
`endif

    logic clk;
    logic rst;

    dbg_disp_sched_if #(.NSRC(NSRC), .SEL_W(SEL_W)) bus ();

    dbg_disp_sched #(
        .NSRC(NSRC),
        .SEL_W(SEL_W),
        .SCAN_DIV(SCAN_DIV),
        .PAGE_DIV(PAGE_DIV)
`ifdef DBG_PAGE_BANNER_EN
        ,
        .BANNER_TICKS(BANNER_TICKS)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Source values as the environment sees them
    logic [15:0]     srcv [NSRC];
    logic [3:0]      dotv [NSRC];
    logic [NSRC-1:0] valid;

    // Reference model state
    int          m_scan;
    int          m_pcnt;
    int          m_page;
    bit          m_manual;
    bit          m_chg;
    logic [15:0] m_data;
    logic [3:0]  m_dots;
    int          m_banner;

    logic        frz;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic setSource(input int i, input logic [15:0] v, input logic [3:0] d);
        srcv[i] = v;
        dotv[i] = d;
        bus.src_data[i*16 +: 16] = v;
        bus.src_dots[i*4 +: 4]   = d;
    endtask

    task automatic setValid(input logic [NSRC-1:0] v);
        valid         = v;
        bus.src_valid = v;
    endtask

    // First valid index after p, wrapping; p itself if nothing else valid
    function automatic int nextValid(input int p, input logic [NSRC-1:0] v);
        for (int k = 1; k < NSRC; k++) begin
            if (v[(p + k) % NSRC]) return (p + k) % NSRC;
        end
        return p;
    endfunction

    task automatic modelReset();
        m_scan   = 0;
        m_pcnt   = 0;
        m_page   = 0;
        m_manual = 0;
        m_chg    = 0;
        m_data   = 16'h0;
        m_dots   = 4'h0;
        m_banner = 0;
    endtask

    // One clock of the specified behaviour, using inputs seen before the edge
    task automatic modelStep(input bit bn, input bit bm, input bit fz);
        bit ce;
        bit autoAdv;
        bit nxt;
        int newPage;
        ce      = (m_scan == SCAN_DIV - 1);
        autoAdv = !m_manual && !fz && ce && (m_pcnt == PAGE_DIV - 1);
        nxt     = bn && !fz;
        newPage = (autoAdv || nxt) ? nextValid(m_page, valid) : m_page;

        if (bm) m_pcnt = 0;
        else if (!m_manual) begin
            if (nxt) m_pcnt = 0;
            else if (!fz && ce) m_pcnt = (m_pcnt + 1) % PAGE_DIV;
        end

        if (!fz) begin
`ifdef DBG_PAGE_BANNER_EN
            if (m_chg) begin
                m_data   = 16'hE000 | 16'(m_page);
                m_dots   = 4'b1000;
                m_banner = BANNER_TICKS;
            end else if (ce) begin
                if (m_banner > 1) m_banner--;
                else begin
                    m_banner = 0;
                    m_data   = valid[m_page] ? srcv[m_page] : 16'h0;
                    m_dots   = valid[m_page] ? dotv[m_page] : 4'h0;
                end
            end
`else
            if (ce || m_chg) begin
                m_data = valid[m_page] ? srcv[m_page] : 16'h0;
                m_dots = valid[m_page] ? dotv[m_page] : 4'h0;
            end
`endif
        end

        m_chg    = (newPage != m_page);
        m_page   = newPage;
        m_manual = m_manual ^ bm;
        m_scan   = (m_scan + 1) % SCAN_DIV;
    endtask

    task automatic compareAll();
        checkOutput("scan_ce",  bus.scan_ce,  (m_scan == SCAN_DIV - 1));
        checkOutput("out_data", bus.out_data, m_data);
        checkOutput("out_dots", bus.out_dots, m_dots);
        checkOutput("page",     bus.page,     m_page);
        checkOutput("manual",   bus.manual,   m_manual);
    endtask

    // Drive one cycle of controls, advance model, then check all outputs
    task automatic applyStimulus(input bit bn, input bit bm, input bit fz);
        bus.btn_next = bn;
        bus.btn_mode = bm;
        bus.freeze   = fz;
        @(posedge clk);
        modelStep(bn, bm, fz);
        #1;
        compareAll();
        bus.btn_next = 1'b0;
        bus.btn_mode = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_scan_ce",  bus.scan_ce,  0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_dots", bus.out_dots, 0);
        checkOutput("rst_page",     bus.page,     0);
        checkOutput("rst_manual",   bus.manual,   0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("rst_hold_data", bus.out_data, 0);
        checkOutput("rst_hold_page", bus.page,     0);
        rst = 1'b0;
    endtask

    initial begin
        int seq[$];
        int prevPage;
        int exp3[3];
        bit hit;

        rst          = 1'b0;
        frz          = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_mode = 1'b0;
        bus.freeze   = 1'b0;
        bus.src_data = '0;
        bus.src_dots = '0;
        setSource(0, 16'h1234, 4'h1);
        setSource(1, 16'hABCD, 4'h2);
        setSource(2, 16'h5A5A, 4'h4);
        setSource(3, 16'h0F0F, 4'h8);
        setValid(4'b1111);
        modelReset();

        // Power-on reset
        #1 rst = 1'b1;
        #10;
        checkOutput("por_out_data", bus.out_data, 0);
        checkOutput("por_page",     bus.page,     0);
        checkOutput("por_manual",   bus.manual,   0);
        checkOutput("por_scan_ce",  bus.scan_ce,  0);
        rst = 1'b0;

        // Reset release: first scan tick loads source 0
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
        checkOutput("p1_data", bus.out_data, 16'h1234);
        checkOutput("p1_dots", bus.out_dots, 4'h1);
        checkOutput("p1_page", bus.page, 0);

        // AUTO rotation skipping absent source 2
        setValid(4'b1011);
        prevPage = 0;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(0, 0, 0);
            if (int'(bus.page) != prevPage) begin
                prevPage = int'(bus.page);
                seq.push_back(prevPage);
            end
        end
        checkOutput("p2_nchg", (seq.size() >= 3), 1);
        exp3 = '{1, 3, 0};
        for (int i = 0; i < 3 && i < seq.size(); i++) checkOutput("p2_seq", seq[i], exp3[i]);

        // MANUAL stepping with btn_next
        doReset();
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("p3_page", bus.page, exp3[i]);
            for (int j = 0; j < 5; j++) applyStimulus(0, 0, 0);
        end
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0);
        checkOutput("p3_manual", bus.manual, 1);
        checkOutput("p3_hold",   bus.page,   0);

        // Freeze holds display and page despite source change and btn_next
        applyStimulus(0, 0, 1);
        setSource(0, 16'hBEEF, 4'h3);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1);
        checkOutput("p4_frz_data", bus.out_data, 16'h1234);
        checkOutput("p4_frz_page", bus.page, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
        checkOutput("p4_thaw_data", bus.out_data, 16'hBEEF);

        // Same-cycle btn_next and auto-advance give one step
        setValid(4'b1111);
        applyStimulus(0, 1, 0);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (!m_manual && m_page == 0 && m_scan == SCAN_DIV - 1 && m_pcnt == PAGE_DIV - 1) begin
                applyStimulus(1, 0, 0);
                hit = 1;
            end else begin
                applyStimulus(0, 0, 0);
            end
        end
        checkOutput("p5_hit",  hit, 1);
        checkOutput("p5_page", bus.page, 1);

        // Only source 0 present: page settles on 0 and stays
        setValid(4'b0001);
        for (int i = 0; i < 40; i++) applyStimulus($urandom_range(0, 3) == 0, 0, 0);
        checkOutput("p5_only0", bus.page, 0);

        // Reset in the middle of page 2
        doReset();
        setSource(1, 16'hABCD, 4'h2);
        setValid(4'b1111);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("p6_page2", bus.page, 2);
        applyStimulus(0, 0, 0);
        doReset();

        // Page change to 1: banner (if enabled) or source 1 next cycle
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
`ifdef DBG_PAGE_BANNER_EN
        checkOutput("p6_banner_data", bus.out_data, 16'hE001);
        checkOutput("p6_banner_dots", bus.out_dots, 4'b1000);
`else
        checkOutput("p6_src1_data", bus.out_data, 16'hABCD);
        checkOutput("p6_src1_dots", bus.out_dots, 4'h2);
`endif
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0);

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 2) doReset();
            if ($urandom_range(0, 99) < 5)
                setSource($urandom_range(0, NSRC - 1), 16'($urandom), 4'($urandom));
            if ($urandom_range(0, 99) < 3) setValid(4'($urandom));
            if ($urandom_range(0, 99) < 5) frz = !frz;
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, frz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dbg_disp_sched.md
Name: dbg_disp_sched

Overview:
- Scheduler that shares the 4-digit 7-segment debug display between up to NSRC debug sources.
- Generates the scan clock-enable for the digit multiplexer and rotates pages automatically or manually.
- Registers a tear-free snapshot of the selected source as the display word (16-bit hex value, 4 dots).
- Sits between internal debug taps and the digit scan/segment decoder; drives that decoder's data0/data1 inputs.

Parameters:
- NSRC, 4, number of sources (2..2**SEL_W).
- SEL_W, 2, page index width.
- SCAN_DIV, 50000, clk cycles per scan tick (>=2).
- PAGE_DIV, 2000, scan ticks per auto page (>=1).
- BANNER_TICKS, 500, scan ticks the page banner is shown (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_data  in  NSRC*16  source values; source i at [16i+15:16i].
- src_dots  in  NSRC*4  source dot patterns; source i at [4i+3:4i].
- src_valid  in  NSRC  source present; absent sources are skipped.
- btn_next  in  1  single-cycle pulse, pre-debounced: advance page.
- btn_mode  in  1  single-cycle pulse: toggle AUTO/MANUAL.
- freeze  in  1  level: hold display and page.
- scan_ce  out  1  one-cycle scan tick to the digit multiplexer.
- out_data  out  16  display value (data0 of decoder).
- out_dots  out  4  dot pattern (data1 of decoder).
- page  out  SEL_W  currently selected source.
- manual  out  1  1 = MANUAL mode.

Behaviour:
Reset:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- While rst is asserted: scan_ce=0, out_data=0, out_dots=0, page=0, manual=0 (AUTO), all counters 0.
- Reset takes effect immediately at any point, including mid-page or mid-banner.

Prescaler:
- scan counter runs 0..SCAN_DIV-1 continuously, including while frozen.
- scan_ce=1 for exactly the cycle in which the counter equals SCAN_DIV-1; it wraps to 0 the same cycle.

Mode FSM (states AUTO and MANUAL):
- btn_mode toggles the state.
- Entering either state clears the page counter.

Page counter:
- Counts scan_ce only in AUTO with freeze=0.
- When it is at PAGE_DIV-1 and scan_ce=1, it raises an auto-advance and wraps to 0.

Advance:
- Sources: auto-advance, or btn_next in either mode.
- Target: next index after page (modulo NSRC) with src_valid=1.
- If no other source is valid, page holds.
- An auto-advance and btn_next in the same cycle produce a single step.
- btn_next in AUTO also clears the page counter.
- btn_mode and btn_next in the same cycle: the toggle and one step both apply.

Freeze:
- freeze=1 blocks advances, holds the page counter, ignores btn_next, and holds out_data/out_dots.
- btn_mode is still honoured while frozen.

Snapshot:
- out_data/out_dots load the selected source on every scan_ce when freeze=0.
- Also forced to load the cycle after page changes, giving 1-cycle latency from page change to new data.
- If src_valid[page]=0 at load: out_data=0, out_dots=0.

Optional Feature:
- Macro: DBG_PAGE_BANNER_EN.
- Defined: after any page change, out_data={4'hE,4'h0,4'h0,zero-extended page}, out_dots=4'b1000, for BANNER_TICKS scan ticks.
  - Snapshot loads are suppressed during the banner; normal loading resumes on the next scan_ce after the banner ends.
  - A new page change restarts the banner.
  - freeze=1 holds the banner counter.
- Undefined: no banner logic; page changes load source data as above.

Test Plan:
(Bench parameters: NSRC=4, SCAN_DIV=4, PAGE_DIV=3, BANNER_TICKS=2.)
- Reset release, all valid, src0=16'h1234 dots 4'h1 -> scan_ce every 4th cycle; out_data=16'h1234 after first scan_ce; page=0, manual=0.
- Run AUTO, src_valid=4'b1011 -> page sequence 0,1,3,0, advancing every 12 cycles; out_data follows source within 1 cycle of each change.
- btn_mode pulse then 3 btn_next pulses -> manual=1; page 0->1->3->0; no advance over 100 cycles without a pulse.
- freeze=1 while src0 changes to 16'hBEEF, plus btn_next -> out_data stays 16'h1234, page holds; freeze=0 -> 16'hBEEF on next scan_ce.
- Same-cycle btn_next and auto-advance at page 0 -> page=1, not 2; only src_valid=4'b0001 -> page stays 0 indefinitely.
- rst asserted mid-page at page=2 -> outputs immediately 0, manual=0; with DBG_PAGE_BANNER_EN, page change to 1 -> out_data=16'hE001 for 2 scan ticks, then source 1 data.
